// File: rtl/traffic_pkg.sv
// Shared types and lamp decoding for the N-phase traffic sequencer.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2
  } state_t;

  localparam logic [1:0] LIGHT_GREEN  = 2'b10;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b00;

  // Only the active phase ever shows a non-red lamp.
  function automatic logic [1:0] lamp_code(input state_t st, input logic [3:0] active,
                                           input logic [3:0] idx);
    logic [1:0] code;
    code = LIGHT_RED;
    if (active == idx) begin
      case (st)
        S_GREEN:  code = LIGHT_GREEN;
        S_YELLOW: code = LIGHT_YELLOW;
        default:  code = LIGHT_RED;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/rr_phase_picker.sv
// Combinational round-robin search: first set request at rr, rr+1, ... wrapping.
module rr_phase_picker #(
  parameter int NUM_PHASES = 5,
  localparam int PW = $clog2(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] req,
  input  logic [PW-1:0]         rr,
  output logic [PW-1:0]         grant,
  output logic                  any_req
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        grant = PW'(idx);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// N-phase traffic sequencer: all-red / green / yellow cycle with round-robin
// fairness between competing phases and an emergency preempt path.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = 5,
  parameter int MIN_GREEN   = 5,
  parameter int MAX_GREEN   = 10,
  parameter int YELLOW_CYC  = 2,
  parameter int ALL_RED_CYC = 1,
  localparam int PW = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PHASES-1:0]   sensor,
  input  logic                    preempt,
  input  logic [PW-1:0]           preempt_phase,
  output logic [2*NUM_PHASES-1:0] lights,
  output logic [PW-1:0]           active_phase,
  output logic                    phase_busy
);

  localparam int TMAX = (YELLOW_CYC > ALL_RED_CYC) ? YELLOW_CYC : ALL_RED_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam int GW   = $clog2(MAX_GREEN + 1);

  localparam logic [TW-1:0] Y_LOAD  = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] AR_LOAD = TW'(ALL_RED_CYC - 1);
  localparam logic [GW-1:0] G_MIN   = GW'(MIN_GREEN);
  localparam logic [GW-1:0] G_MAX   = GW'(MAX_GREEN);

  state_t                  state, state_nxt;
  logic [TW-1:0]           tmr, tmr_nxt;
  logic [GW-1:0]           gtime, gtime_nxt, gtime_inc;
  logic [PW-1:0]           rr, rr_nxt;
  logic [PW-1:0]           active, active_nxt, p_next;
  logic [PW-1:0]           grant;
  logic                    any_req;
  logic                    pre_valid, pre_hold, pre_cut;
  logic                    own_req, other_req;
  logic [NUM_PHASES-1:0]   own_mask;

  rr_phase_picker #(.NUM_PHASES(NUM_PHASES)) u_picker (
    .req     (sensor),
    .rr      (rr),
    .grant   (grant),
    .any_req (any_req)
  );

  // An out-of-range target is treated exactly like no preempt at all.
  assign pre_valid = preempt && (int'(preempt_phase) < NUM_PHASES);
  assign pre_hold  = pre_valid && (preempt_phase == active);
  assign pre_cut   = pre_valid && (preempt_phase != active);

  assign own_mask  = NUM_PHASES'(1) << active;
  assign own_req   = |(sensor & own_mask);
  assign other_req = |(sensor & ~own_mask);

  assign p_next    = (int'(active) == NUM_PHASES - 1) ? '0 : active + PW'(1);
  assign gtime_inc = (gtime >= G_MAX) ? gtime : gtime + GW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_ALL_RED;
      tmr    <= AR_LOAD;
      gtime  <= '0;
      rr     <= '0;
      active <= '0;
    end else begin
      state  <= state_nxt;
      tmr    <= tmr_nxt;
      gtime  <= gtime_nxt;
      rr     <= rr_nxt;
      active <= active_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tmr_nxt    = tmr;
    gtime_nxt  = gtime;
    rr_nxt     = rr;
    active_nxt = active;
    case (state)
      S_ALL_RED: begin
        if (tmr != '0) begin
          tmr_nxt = tmr - TW'(1);
        end else if (pre_valid) begin
          state_nxt  = S_GREEN;
          active_nxt = preempt_phase;
          gtime_nxt  = GW'(1);
        end else if (any_req) begin
          state_nxt  = S_GREEN;
          active_nxt = grant;
          gtime_nxt  = GW'(1);
        end
      end
      S_GREEN: begin
        if (pre_cut) begin
          // Emergency cut: fairness pointer is left where it was.
          state_nxt = S_YELLOW;
          tmr_nxt   = Y_LOAD;
        end else if (pre_hold) begin
          gtime_nxt = gtime_inc;
        end else if ((gtime >= G_MIN && !own_req) || (gtime >= G_MAX && other_req)) begin
          state_nxt = S_YELLOW;
          tmr_nxt   = Y_LOAD;
          rr_nxt    = p_next;
        end else begin
          gtime_nxt = gtime_inc;
        end
      end
      S_YELLOW: begin
        if (tmr != '0) begin
          tmr_nxt = tmr - TW'(1);
        end else begin
          state_nxt = S_ALL_RED;
          tmr_nxt   = AR_LOAD;
        end
      end
      default: begin
        state_nxt = S_ALL_RED;
        tmr_nxt   = AR_LOAD;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_lamp
    assign lights[2*i +: 2] = lamp_code(state, 4'(active), 4'(i));
  end

  assign active_phase = active;
  assign phase_busy   = (state == S_GREEN) || (state == S_YELLOW);

endmodule
